// File: rtl/trng_conditioner.sv
// trng_conditioner: ring-oscillator sampler, von Neumann debiaser, word packer and FWFT FIFO
// Ports: wb_clk_i clock; wb_rst_n async active-low reset; enable_i sampling enable;
//   raw_bit_i asynchronous entropy bit; clr_fail_i clears health_fail_o;
//   rnd_data_o/rnd_valid_o/rnd_ready_i FIFO head read port; fifo_level_o occupancy;
//   health_fail_o sticky repetition-count failure.
// Build option: define TRNG_HEALTH_EN to include the repetition-count health test.
module trng_conditioner #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n,
  input  logic                          enable_i,
  input  logic                          raw_bit_i,
  input  logic                          clr_fail_i,
  output logic [WORD_W-1:0]             rnd_data_o,
  output logic                          rnd_valid_o,
  input  logic                          rnd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          health_fail_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORD_W + 1);
  typedef enum logic {FIRST, SECOND} state_t;
  state_t state, state_nxt;
  logic s1, s2, a, emit, complete, push, pop, stall, flush, block;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_bit_i;
      s2 <= s1;
    end
  assign complete = cnt == CW'(WORD_W);
  assign pop      = rnd_valid_o & rnd_ready_i;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign push     = complete & ((level != LW'(FIFO_DEPTH)) | pop) & ~block;
  // Only a completed word that cannot be written holds back the debiaser
  assign stall    = complete & ~push;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) state <= FIRST;
    else state <= state_nxt;
  always_comb
    state_nxt = (!enable_i || flush) ? FIRST : stall ? state : (state == FIRST ? SECOND : FIRST);
  always_comb
    emit = enable_i & ~flush & ~stall & (state == SECOND) & (a != s2);
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      a     <= 1'b0;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (enable_i && !stall && state == FIRST) a <= s2;
      if (emit) shreg <= {shreg[WORD_W-2:0], a};
      if (!enable_i || flush) cnt <= '0;
      else if (push) cnt <= emit ? CW'(1) : '0;
      else if (emit) cnt <= cnt + CW'(1);
    end
  always_ff @(posedge wb_clk_i)
    if (push) mem[wp] <= shreg;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  assign rnd_valid_o  = level != '0;
  // Storage is not reset, so the head is masked until a word is present
  assign rnd_data_o   = rnd_valid_o ? mem[rp] : '0;
  assign fifo_level_o = level;
`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  logic [RW-1:0] rct;
  logic prev, fail;
  // A count of zero means no previous sample, so the next one starts a fresh run
  assign flush = rct == RW'(RCT_CUTOFF);
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      rct  <= '0;
      prev <= 1'b0;
      fail <= 1'b0;
    end else begin
      if (flush) fail <= 1'b1;
      else if (clr_fail_i) fail <= 1'b0;
      if (clr_fail_i && !flush) rct <= '0;
      else if (enable_i) begin
        prev <= s2;
        rct  <= (rct == '0 || s2 != prev) ? RW'(1) : flush ? rct : rct + RW'(1);
      end
    end
  assign health_fail_o = fail;
  assign block         = fail | flush;
`else
  localparam int UNUSED_RCT_CUTOFF = RCT_CUTOFF;
  logic unused_clr;
  assign unused_clr    = clr_fail_i;
  assign flush         = 1'b0;
  assign block         = 1'b0;
  assign health_fail_o = 1'b0;
`endif
endmodule

// File: tb/tb_trng_conditioner.sv
// tb_trng_conditioner: directed and random stimulus against a queue-based reference model
module tb_trng_conditioner;
  localparam int W = 32;
  localparam int D = 4;
  localparam int CUT = 32;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, raw = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [W-1:0] data;
  logic valid, hf;
  logic [2:0] level;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  trng_conditioner #(.WORD_W(W), .FIFO_DEPTH(D), .RCT_CUTOFF(CUT)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .enable_i(en), .raw_bit_i(raw), .clr_fail_i(clr),
    .rnd_data_o(data), .rnd_valid_o(valid), .rnd_ready_i(rdy), .fifo_level_o(level),
    .health_fail_o(hf));
  logic m_s1, m_s2, m_a, m_has, m_prev, m_fail;
  int m_rct;
  bit m_bits[$];
  logic [W-1:0] m_fifo[$];
  task automatic m_reset();
    m_s1 = 0; m_s2 = 0; m_a = 0; m_has = 0; m_prev = 0; m_fail = 0; m_rct = 0;
    m_bits.delete();
    m_fifo.delete();
  endtask
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("valid", W'(valid), W'(m_fifo.size() > 0));
    chk("data", data, m_fifo.size() > 0 ? m_fifo[0] : '0);
    chk("level", W'(level), W'(m_fifo.size()));
    chk("health", W'(hf), W'(m_fail));
  endtask
  task automatic model();
    logic s, nf, pop, push, stall, emit, eb;
    logic [W-1:0] w;
    s = m_s2; m_s2 = m_s1; m_s1 = raw;
`ifdef TRNG_HEALTH_EN
    nf = (m_rct == CUT);
`else
    nf = 1'b0;
`endif
    pop = m_fifo.size() > 0 && rdy;
    push = m_bits.size() == W && (m_fifo.size() < D || pop) && !(m_fail || nf);
    stall = m_bits.size() == W && !push;
    emit = 0; eb = 0;
    if (!en || nf) m_has = 0;
    else if (!stall) begin
      if (!m_has) begin m_a = s; m_has = 1; end
      else begin
        m_has = 0;
        if (m_a != s) begin emit = 1; eb = m_a; end
      end
    end
    w = '0;
    foreach (m_bits[i]) if (m_bits[i]) w[W-1-i] = 1'b1;
    if (pop) void'(m_fifo.pop_front());
    if (push) m_fifo.push_back(w);
    if (nf) m_fifo.delete();
    if (!en || nf || push) m_bits.delete();
    if (emit) m_bits.push_back(eb);
`ifdef TRNG_HEALTH_EN
    if (clr && !nf) m_rct = 0;
    else if (en) begin
      m_rct = (m_rct == 0 || s != m_prev) ? 1 : (m_rct == CUT ? CUT : m_rct + 1);
      m_prev = s;
    end
    if (nf) m_fail = 1;
    else if (clr) m_fail = 0;
`endif
  endtask
  task automatic step(input logic r, input logic e, input logic rd, input logic c);
    raw = r; en = e; rdy = rd; clr = c;
    @(posedge clk);
    model();
    #1 chk_all();
  endtask
  initial begin
    m_reset();
    #12;
    chk_all();
    chk("rst_level", W'(level), '0);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(1'(i % 2), 1, 0, 0);
    chk("t1_word", data, 32'h0000_0000);
    chk("t1_valid", W'(valid), 1);
    chk("t1_level", W'(level), 1);
    step(0, 0, 1, 0);
    chk("t1_pop", W'(level), 0);
    repeat (3) step(1, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(1'((i + 1) % 2), 1, 0, 0);
    chk("t2_ones", data, 32'hFFFF_FFFF);
    step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(1'(i % 4 == 1 || i % 4 == 2), 1, 0, 0);
    chk("t2_alt", data, 32'h5555_5555);
    step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    for (int i = 0; i < 1200; i++) step(1'($urandom), 1, 0, 0);
    chk("t3_full", W'(level), 4);
    step(1'($urandom), 1, 1, 0);
    chk("t3_pushpop", W'(level), 4);
    repeat (6) step(0, 0, 1, 0);
    chk("t3_drained", W'(level), 0);
    repeat (2) step(0, 0, 0, 0);
    for (int i = 0; i < 42; i++) step(1'(i % 2), 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(1'((i + 1) % 2), 1, 0, 0);
    chk("t4_word", data, 32'hFFFF_FFFF);
    chk("t4_level", W'(level), 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 2000 && m_fifo.size() < 2; i++) step(1'($urandom), 1, 0, 0);
    chk("t5_queued", W'(level), 2);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
`ifdef TRNG_HEALTH_EN
    chk("t5_fail", W'(hf), 1);
    chk("t5_flush", W'(level), 0);
    chk("t5_valid", W'(valid), 0);
    for (int i = 0; i < 4; i++) step(1'(i % 2), 1, 0, 0);
    step(0, 1, 0, 1);
    chk("t5_clear", W'(hf), 0);
    for (int i = 0; i < 1000 && m_fifo.size() == 0; i++) step(1'($urandom), 1, 0, 0);
    chk("t5_recover", W'(valid), 1);
`else
    chk("t5_nofail", W'(hf), 0);
    chk("t5_kept", W'(level), 2);
`endif
    repeat (5) step(0, 0, 1, 0);
    for (int i = 0; i < 3000 && m_fifo.size() < 3; i++) step(1'($urandom), 1, 0, 0);
    repeat (5) step(1'($urandom), 1, 0, 0);
    chk("t6_three", W'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", W'(valid), 0);
    chk("t6_data", data, '0);
    chk("t6_level", W'(level), 0);
    chk("t6_health", W'(hf), 0);
    m_reset();
    @(posedge clk);
    #1 chk_all();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'(i % 2), 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
